// File: rtl/adder_norm_seq.sv
// Sequential post-add normalizer: renormalizes the raw FP32 adder result and emits a packed IEEE-754 word.
// Define ADDER_NORM_LZC_EN for single-cycle leading-zero normalization; default is iterative 1-bit shifting.
module adder_norm_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+1:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   dataR,
  output logic                    ovf,
  output logic                    unf
);

  localparam int MW = FRAC_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [EXP_W-1:0]       exp_q, exp_d;
  logic [MW-1:0]          mant_q, mant_d;
  logic [EXP_W+FRAC_W:0]  data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   out_valid_q, out_valid_d;
  logic [EXP_W-1:0]       exp_inc;

`ifdef ADDER_NORM_LZC_EN
  logic [EXP_W-1:0]       lz;
  logic [FRAC_W-1:0]      frac_lz;

  // Leading zeros of {hidden, fraction}; the highest set bit wins because it is visited last.
  always_comb begin
    lz = EXP_W'(FRAC_W + 1);
    for (int i = 0; i <= FRAC_W; i++) begin
      if (mant_q[i]) lz = EXP_W'(FRAC_W - i);
    end
    frac_lz = FRAC_W'(mant_q << lz);
  end
`endif

  // NOTE: every variable gets its default before the case so no path can leave one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = 1'b0;
    exp_inc     = exp_q + EXP_ONE;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = NORM;
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
        end
      end
      NORM: begin
        state_d = DONE;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (exp_q == EXP_MAX) begin
          data_d = {sign_q, EXP_MAX, mant_q[FRAC_W-1:0]};
        end else if (mant_q == '0) begin
          data_d = '0;
        end else if (mant_q[MW-1]) begin
          // Carry: right shift folded into the same cycle; the shifted-out bit is truncated.
          if (exp_inc == EXP_MAX) begin
            data_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            ovf_d  = 1'b1;
          end else begin
            data_d = {sign_q, exp_inc, mant_q[FRAC_W:1]};
          end
        end else if (mant_q[MW-2]) begin
          data_d = {sign_q, exp_q, mant_q[FRAC_W-1:0]};
        end else begin
`ifdef ADDER_NORM_LZC_EN
          if (lz >= exp_q) begin
            data_d = '0;
            unf_d  = 1'b1;
          end else begin
            data_d = {sign_q, exp_q - lz, frac_lz};
          end
`else
          if (exp_q <= EXP_ONE) begin
            data_d = '0;
            unf_d  = 1'b1;
          end else begin
            state_d = NORM;
            mant_d  = mant_q << 1;
            exp_d   = exp_q - EXP_ONE;
          end
`endif
        end
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE and stays up until the handshake.
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign dataR     = data_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_adder_norm_seq.sv
// Self-checking bench for adder_norm_seq: directed cases, backpressure, mid-flight reset and
// randomized transactions against an arithmetic reference model.
module tb_adder_norm_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dataR;
  logic        ovf;
  logic        unf;

  int total = 0;
  int bad   = 0;

  adder_norm_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataR     (dataR),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value semantics of normalization, with mantissa treated as an integer.
  function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                output logic [31:0] d, output logic o, output logic u,
                                output int sh);
    int mm;
    int ee;
    mm = int'(m);
    ee = int'(e);
    d  = 32'h0;
    o  = 1'b0;
    u  = 1'b0;
    sh = 0;
    if (ee == 255) begin
      d = {s, 8'hFF, m[22:0]};
    end else if (mm == 0) begin
      d = 32'h0;
    end else if (mm >= (1 << 24)) begin
      ee = ee + 1;
      if (ee == 255) begin
        o = 1'b1;
        d = {s, 8'hFF, 23'h0};
      end else begin
        d = {s, 8'(ee), 23'((mm / 2) % (1 << 23))};
      end
    end else begin
      while (mm < (1 << 23)) begin
        if (ee <= 1) begin
          u = 1'b1;
          break;
        end
        mm = mm * 2;
        ee = ee - 1;
        sh++;
      end
      if (u) d = 32'h0;
      else   d = {s, 8'(ee), 23'(mm - (1 << 23))};
    end
  endfunction

  // One full transaction; checks result, latency and (if hold>0) stability under backpressure.
  task automatic do_txn(input string name, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input int hold,
                        output logic [31:0] obs_d, output logic obs_o, output logic obs_u,
                        output int obs_lat);
    logic [31:0] exp_d;
    logic        exp_o, exp_u;
    int          exp_s, lat_exp, wait_n;
    model(s, e, m, exp_d, exp_o, exp_u, exp_s);
`ifdef ADDER_NORM_LZC_EN
    lat_exp = 2;
`else
    lat_exp = 2 + exp_s;
`endif
    wait_n = 0;
    while (!in_ready && wait_n < 64) begin
      @(negedge clk);
      wait_n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    @(negedge clk);
    in_valid  = 1'b0;
    in_sign   = 1'($urandom);
    in_exp    = 8'($urandom);
    in_mant   = 25'($urandom);
    obs_lat = 0;
    while (out_valid !== 1'b1 && obs_lat < 64) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_d = dataR;
    obs_o = ovf;
    obs_u = unf;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s out_valid timeout: got %b want 1", name, out_valid);
    end
    total++;
    if (obs_lat != lat_exp) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, obs_lat, lat_exp);
    end
    total++;
    if ({obs_d, obs_o, obs_u} !== {exp_d, exp_o, exp_u}) begin
      bad++;
      $display("FAIL %s result e=%h m=%h: got %h ovf=%b unf=%b want %h ovf=%b unf=%b",
               name, e, m, obs_d, obs_o, obs_u, exp_d, exp_o, exp_u);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s in_ready while busy: got %b want 0", name, in_ready);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, dataR, ovf, unf} !== {1'b1, 1'b0, exp_d, exp_o, exp_u}) begin
        bad++;
        $display("FAIL %s hold%0d: got v=%b r=%b %h want v=1 r=0 %h", name, h,
                 out_valid, in_ready, dataR, exp_d);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s release: got v=%b r=%b want v=0 r=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h0;
    in_mant   = 25'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, dataR, ovf, unf} !== 35'h0) begin
      bad++;
      $display("FAIL reset outputs: got v=%b d=%h o=%b u=%b want all 0", out_valid, dataR, ovf, unf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] d;
    logic        o, u;
    int          lat;
    do_txn("t1_1p5", 1'b0, 8'h7F, 25'h0C00000, 0, d, o, u, lat);
    total++;
    if ({d, o, u} !== {32'h3FC00000, 2'b00}) begin
      bad++;
      $display("FAIL t1 spec: got %h %b%b want 3fc00000 00", d, o, u);
    end
    do_txn("t2_carry", 1'b0, 8'h7F, 25'h1800000, 0, d, o, u, lat);
    total++;
    if ({d, o, u, lat} !== {32'h40400000, 2'b00, 32'd2}) begin
      bad++;
      $display("FAIL t2 spec: got %h %b%b lat=%0d want 40400000 00 lat=2", d, o, u, lat);
    end
    do_txn("t3_lshift", 1'b0, 8'h80, 25'h0200000, 0, d, o, u, lat);
    total++;
    if ({d, o, u} !== {32'h3F000000, 2'b00}) begin
      bad++;
      $display("FAIL t3 spec: got %h %b%b want 3f000000 00", d, o, u);
    end
    do_txn("t4_zero", 1'b1, 8'h55, 25'h0, 0, d, o, u, lat);
    total++;
    if ({d, o, u} !== {32'h0, 2'b00}) begin
      bad++;
      $display("FAIL t4 zero: got %h %b%b want 00000000 00", d, o, u);
    end
    do_txn("t4_ovf", 1'b0, 8'hFE, 25'h1000000, 0, d, o, u, lat);
    total++;
    if ({d, o, u} !== {32'h7F800000, 2'b10}) begin
      bad++;
      $display("FAIL t4 ovf: got %h %b%b want 7f800000 10", d, o, u);
    end
    do_txn("t4_unf", 1'b0, 8'h01, 25'h0400000, 0, d, o, u, lat);
    total++;
    if ({d, o, u} !== {32'h0, 2'b01}) begin
      bad++;
      $display("FAIL t4 unf: got %h %b%b want 00000000 01", d, o, u);
    end
    do_txn("t4_nan", 1'b1, 8'hFF, 25'h1400001, 0, d, o, u, lat);
    total++;
    if ({d, o, u} !== {32'hFFC00001, 2'b00}) begin
      bad++;
      $display("FAIL t4 nan: got %h %b%b want ffc00001 00", d, o, u);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic        o, u;
    int          lat;
    do_txn("t5_bp", 1'b0, 8'h7F, 25'h0C00000, 3, d, o, u, lat);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        o, u;
    int          lat;
    bit          seen;
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'h80;
    in_mant  = 25'h0200000;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) seen = 1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL t6 dropped txn: got out_valid=1 want never");
    end
    do_txn("t6_after", 1'b0, 8'h7F, 25'h0C00000, 0, d, o, u, lat);
    total++;
    if ({d, o, u} !== {32'h3FC00000, 2'b00}) begin
      bad++;
      $display("FAIL t6 after reset: got %h %b%b want 3fc00000 00", d, o, u);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        o, u;
    int          lat;
    for (int k = 0; k < 6; k++) begin
      do_txn("b2b", 1'($urandom), 8'($urandom_range(1, 254)), 25'($urandom) >> $urandom_range(0, 24),
             0, d, o, u, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        o, u;
    int          lat;
    logic [7:0]  e;
    logic [24:0] m;
    for (int k = 0; k < 200; k++) begin
      e = 8'($urandom_range(1, 254));
      m = 25'($urandom) >> $urandom_range(0, 24);
      case ($urandom_range(0, 9))
        0: m = 25'h0;
        1: e = 8'hFF;
        2: begin e = 8'hFE; m = m | 25'h1000000; end
        3: begin e = 8'($urandom_range(1, 4)); m = m >> $urandom_range(0, 8); end
        default: ;
      endcase
      do_txn("rand", 1'($urandom), e, m, $urandom_range(0, 2), d, o, u, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
